// File: rtl/tick_scheduler.sv
// Shared prescaler driving NCH programmable tick channels. Channel configuration
// arrives over a valid/ready port and takes effect only on a base-tick boundary.
module tick_scheduler #(
    parameter int PRESCALE = 50_000,
    parameter int CHW      = 2,
    parameter int PW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [PW-1:0]       cfg_period,
    input  logic                cfg_en,
    output logic                base_tick,
    output logic [2**CHW-1:0]   tick
);

    localparam int NCH = 2**CHW;
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PRE_MAX = PCW'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_e;

    // Prescaler
    logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
    logic           strobe;
    logic           base_tick_q;

    // Config FSM and pending registers
    state_e         state_q, state_d;
    logic [CHW-1:0] pend_ch_q, pend_ch_d;
    logic [PW-1:0]  pend_period_q, pend_period_d;
    logic           pend_en_q, pend_en_d;
    logic           apply;

    // Channel state
    logic [PW-1:0]  cnt_q    [NCH];
    logic [PW-1:0]  cnt_d    [NCH];
    logic [PW-1:0]  period_q [NCH];
    logic [PW-1:0]  period_d [NCH];
    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] tick_q, tick_d;

    always_comb begin
        strobe    = (pre_cnt_q == PRE_MAX);
        pre_cnt_d = strobe ? '0 : pre_cnt_q + 1'b1;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        pend_ch_d     = pend_ch_q;
        pend_period_d = pend_period_q;
        pend_en_d     = pend_en_q;
        cfg_ready     = 1'b0;
        apply         = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    pend_ch_d     = cfg_ch;
                    pend_period_d = cfg_period;
                    pend_en_d     = cfg_en;
                    state_d       = PEND;
                end
            end
            PEND: begin
                // An accept landing on a strobe is in IDLE that cycle, so it waits for the next one.
                if (strobe) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d   = en_q;
        tick_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            if (apply && (pend_ch_q == CHW'(i))) begin
                // Restart the channel from zero; its tick is suppressed on the applying strobe.
                period_d[i] = pend_period_q;
                en_d[i]     = pend_en_q;
                cnt_d[i]    = '0;
            end else if (strobe && en_q[i] && (period_q[i] != '0)) begin
                if (cnt_q[i] == period_q[i] - 1'b1) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    // NOTE: the channel arrays are a handful of flops, not a RAM, so resetting them is cheap and required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q     <= '0;
            base_tick_q   <= 1'b0;
            state_q       <= IDLE;
            pend_ch_q     <= '0;
            pend_period_q <= '0;
            pend_en_q     <= 1'b0;
            en_q          <= '0;
            tick_q        <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            base_tick_q   <= strobe;
            state_q       <= state_d;
            pend_ch_q     <= pend_ch_d;
            pend_period_q <= pend_period_d;
            pend_en_q     <= pend_en_d;
            en_q          <= en_d;
            tick_q        <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

    assign base_tick = base_tick_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed and randomized bench for tick_scheduler; expectations come from an
// edge-count arithmetic model of the base-tick and channel schedules.
module tb_tick_scheduler;

    localparam int PRESCALE = 4;
    localparam int CHW      = 2;
    localparam int PW       = 16;
    localparam int NCH      = 2**CHW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [PW-1:0]  cfg_period = '0;
    logic           cfg_en = 1'b0;
    logic           base_tick;
    logic [NCH-1:0] tick;

    tick_scheduler #(.PRESCALE(PRESCALE), .CHW(CHW), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .base_tick  (base_tick),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: k counts rising edges since reset release; strobes fall on edges where k%PRESCALE==0.
    int k;
    bit m_pend;
    int m_pch;
    int m_pp;
    bit m_pe;
    int m_apply  [NCH];
    int m_period [NCH];
    bit m_en     [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, k);
    endtask

    function automatic void model_reset();
        k      = 0;
        m_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_apply[i]  = 0;
            m_period[i] = 0;
            m_en[i]     = 1'b0;
        end
    endfunction

    // Channel i ticks on strobes that are a whole multiple of its period after the apply strobe.
    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] r = '0;
        for (int i = 0; i < NCH; i++) begin
            if ((k % PRESCALE == 0) && m_en[i] && (m_period[i] != 0) && (k > m_apply[i]) &&
                ((((k - m_apply[i]) / PRESCALE) % m_period[i]) == 0))
                r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic step(output bit accepted);
        bit acc = cfg_valid && !m_pend;
        @(posedge clk);
        k++;
        if (m_pend && (k % PRESCALE == 0)) begin
            m_period[m_pch] = m_pp;
            m_en[m_pch]     = m_pe;
            m_apply[m_pch]  = k;
            m_pend          = 1'b0;
        end
        if (acc) begin
            m_pend = 1'b1;
            m_pch  = int'(cfg_ch);
            m_pp   = int'(cfg_period);
            m_pe   = cfg_en;
        end
        #1;
        check("base_tick", 32'(base_tick), 32'(k % PRESCALE == 0));
        check("tick",      32'(tick),      32'(exp_tick()));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        accepted = acc;
    endtask

    task automatic idle(input int n);
        bit a;
        cfg_valid = 1'b0;
        repeat (n) step(a);
    endtask

    // Leaves cfg_valid high so consecutive calls form back-to-back writes.
    task automatic write_cfg(input int ch, input int period, input bit en);
        bit a;
        bit done = 1'b0;
        cfg_ch     = CHW'(ch);
        cfg_period = PW'(period);
        cfg_en     = en;
        cfg_valid  = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            step(a);
            if (a) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $error("FAIL write_timeout: ch %0d not accepted within 20 cycles, expected acceptance", ch);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check("reset_tick",      32'(tick),      32'd0);
        check("reset_base_tick", 32'(base_tick), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit a;
        #2;
        do_reset();

        // Idle: base_tick every PRESCALE edges, first on the 4th edge.
        idle(12);

        // Single channel, period 3.
        write_cfg(0, 3, 1'b1);
        idle(30);

        // Period 1 tracks base_tick; period 0 stays silent. Back-to-back writes with valid held.
        write_cfg(1, 1, 1'b1);
        write_cfg(2, 0, 1'b1);
        idle(16);
        write_cfg(3, 2, 1'b1);
        write_cfg(3, 1, 1'b1);
        idle(9);

        // Rewrite a running channel mid-count, then disable it.
        idle(5);
        write_cfg(0, 2, 1'b1);
        idle(20);
        write_cfg(0, 3, 1'b0);
        idle(24);

        // Reset while a config is pending.
        write_cfg(1, 2, 1'b1);
        cfg_valid = 1'b0;
        do_reset();
        idle(16);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cfg_valid  = ($urandom % 4) == 0;
            cfg_ch     = CHW'($urandom);
            cfg_period = PW'($urandom_range(0, 4));
            cfg_en     = ($urandom % 4) != 0;
            step(a);
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
